// File: rtl/fft_bitrev_reorder_pkg.sv
// Shared types and arithmetic helpers for the FFT output reorder stage.
// FFT_OUT_SAT_EN: clamp rounded samples to the output range instead of wrapping.
package fft_pkg;

    localparam int unsigned N_LOG2_DEF = 8;
    localparam int unsigned N_DEF      = 1 << N_LOG2_DEF;
    localparam int unsigned IW_DEF     = 32;
    localparam int unsigned OW_DEF     = 16;
    localparam int unsigned SHIFT_DEF  = 8;

    typedef struct packed {
        logic signed [IW_DEF-1:0] re;
        logic signed [IW_DEF-1:0] im;
    } cplx_t;

    typedef enum logic {
        RD_IDLE,
        RD_RUN
    } rd_state_e;

    // Reverses the low 'bits' bits of x (bits <= 16).
    function automatic logic [15:0] bitrev(input logic [15:0] x, input int unsigned bits);
        logic [15:0] r;
        r = '0;
        for (int unsigned i = 0; i < bits; i++) begin
            r[4'(i)] = x[4'(bits - 1 - i)];
        end
        return r;
    endfunction

    // Round half up, drop 'shift' fractional bits, then fit to 'ow' bits.
    function automatic logic signed [63:0] round_sat(input logic signed [63:0] x,
                                                     input int unsigned shift,
                                                     input int unsigned ow);
        logic signed [63:0] y;
        y = (x + (64'sd1 <<< (shift - 1))) >>> shift;
`ifdef FFT_OUT_SAT_EN
        if (y > ((64'sd1 <<< (ow - 1)) - 64'sd1)) begin
            y = (64'sd1 <<< (ow - 1)) - 64'sd1;
        end else if (y < -(64'sd1 <<< (ow - 1))) begin
            y = -(64'sd1 <<< (ow - 1));
        end
`else
        y = (y <<< (64 - ow)) >>> (64 - ow);
`endif
        return y;
    endfunction

endpackage

// File: rtl/fft_bitrev_reorder_round_sat.sv
// Combinational per-component rescale: round half up, then saturate or wrap.
// Wrap vs. clamp is selected by FFT_OUT_SAT_EN inside fft_pkg::round_sat.
module fft_round_sat
    import fft_pkg::*;
#(
    parameter int unsigned IW    = IW_DEF,
    parameter int unsigned OW    = OW_DEF,
    parameter int unsigned SHIFT = SHIFT_DEF
) (
    input  logic signed [IW-1:0] x_i,
    output logic signed [OW-1:0] y_o
);

    assign y_o = OW'(round_sat(64'(x_i), SHIFT, OW));

endmodule

// File: rtl/fft_bitrev_reorder.sv
// FFT output stage: ping-pong buffer turning bit-reversed frames into natural order.
// Build option FFT_OUT_SAT_EN selects clamping instead of wrapping on rescale.
module fft_bitrev_reorder
    import fft_pkg::*;
#(
    parameter int unsigned N_LOG2 = N_LOG2_DEF,
    parameter int unsigned IW     = IW_DEF,
    parameter int unsigned OW     = OW_DEF,
    parameter int unsigned SHIFT  = SHIFT_DEF
) (
    input  logic                 CLK,
    input  logic                 RST,
    input  logic                 in_valid,
    input  logic signed [IW-1:0] in_r,
    input  logic signed [IW-1:0] in_i,
    output logic signed [OW-1:0] Data_out_r,
    output logic signed [OW-1:0] Data_out_i,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic                 out_first,
    output logic                 out_last,
    output logic                 overflow
);

    localparam int unsigned        N        = 1 << N_LOG2;
    localparam logic [N_LOG2-1:0]  CNT_LAST = '1;

    logic signed [IW-1:0] mem_r_q [2*N];
    logic signed [IW-1:0] mem_i_q [2*N];

    logic                 wr_bank_q, wr_bank_d;
    logic [N_LOG2-1:0]    wr_cnt_q, wr_cnt_d;
    logic [1:0]           full_q, full_d;
    logic                 overflow_q, overflow_d;
    logic                 rd_bank_q, rd_bank_d;
    logic [N_LOG2-1:0]    rd_cnt_q, rd_cnt_d;
    rd_state_e            state_q, state_d;

    logic                 pf_valid_q, pf_valid_d;
    logic                 pf_first_q, pf_first_d;
    logic                 pf_last_q, pf_last_d;
    logic signed [IW-1:0] pf_r_q, pf_r_d, pf_i_q, pf_i_d;

    logic                 out_valid_q, out_valid_d;
    logic                 out_first_q, out_first_d;
    logic                 out_last_q, out_last_d;
    logic signed [OW-1:0] out_r_q, out_r_d, out_i_q, out_i_d;
    logic signed [OW-1:0] rnd_r, rnd_i;

    logic                 wr_en, rd_fire, out_load, pf_free;
    logic [N_LOG2:0]      wr_addr, rd_addr;

    assign wr_en    = in_valid && !full_q[wr_bank_q];
    assign wr_addr  = {wr_bank_q, wr_cnt_q};
    assign rd_addr  = {rd_bank_q, N_LOG2'(bitrev(16'(rd_cnt_q), N_LOG2))};
    // Prefetch stage refills whenever the output register drains, giving 1 sample/clock.
    assign out_load = pf_valid_q && (!out_valid_q || out_ready);
    assign pf_free  = !pf_valid_q || out_load;
    assign rd_fire  = pf_free && ((state_q == RD_RUN) || full_q[rd_bank_q]);

    always_ff @(posedge CLK) begin
        if (wr_en) begin
            mem_r_q[wr_addr] <= in_r;
            mem_i_q[wr_addr] <= in_i;
        end
    end

    fft_round_sat #(.IW(IW), .OW(OW), .SHIFT(SHIFT)) u_rs_r (.x_i(pf_r_q), .y_o(rnd_r));
    fft_round_sat #(.IW(IW), .OW(OW), .SHIFT(SHIFT)) u_rs_i (.x_i(pf_i_q), .y_o(rnd_i));

    always_comb begin
        full_d      = full_q;
        wr_bank_d   = wr_bank_q;
        wr_cnt_d    = wr_cnt_q;
        overflow_d  = overflow_q | (in_valid && full_q[wr_bank_q]);
        rd_bank_d   = rd_bank_q;
        rd_cnt_d    = rd_cnt_q;
        state_d     = state_q;
        pf_valid_d  = pf_valid_q;
        pf_first_d  = pf_first_q;
        pf_last_d   = pf_last_q;
        pf_r_d      = pf_r_q;
        pf_i_d      = pf_i_q;
        out_valid_d = out_valid_q;
        out_first_d = out_first_q;
        out_last_d  = out_last_q;
        out_r_d     = out_r_q;
        out_i_d     = out_i_q;

        if (wr_en) begin
            wr_cnt_d = wr_cnt_q + 1'b1;
            if (wr_cnt_q == CNT_LAST) begin
                full_d[wr_bank_q] = 1'b1;
                wr_bank_d         = !wr_bank_q;
            end
        end

        // Writer and reader never touch the same full bit in one cycle.
        if (rd_fire) begin
            rd_cnt_d   = rd_cnt_q + 1'b1;
            state_d    = RD_RUN;
            pf_valid_d = 1'b1;
            pf_first_d = (rd_cnt_q == '0);
            pf_last_d  = (rd_cnt_q == CNT_LAST);
            pf_r_d     = mem_r_q[rd_addr];
            pf_i_d     = mem_i_q[rd_addr];
            if (rd_cnt_q == CNT_LAST) begin
                full_d[rd_bank_q] = 1'b0;
                rd_bank_d         = !rd_bank_q;
                state_d           = full_q[!rd_bank_q] ? RD_RUN : RD_IDLE;
            end
        end else if (out_load) begin
            pf_valid_d = 1'b0;
        end

        if (out_load) begin
            out_valid_d = 1'b1;
            out_first_d = pf_first_q;
            out_last_d  = pf_last_q;
            out_r_d     = rnd_r;
            out_i_d     = rnd_i;
        end else if (out_ready) begin
            out_valid_d = 1'b0;
        end
    end

    always_ff @(posedge CLK) begin
        if (!RST) begin
            full_q      <= '0;
            wr_bank_q   <= 1'b0;
            wr_cnt_q    <= '0;
            overflow_q  <= 1'b0;
            rd_bank_q   <= 1'b0;
            rd_cnt_q    <= '0;
            state_q     <= RD_IDLE;
            pf_valid_q  <= 1'b0;
            pf_first_q  <= 1'b0;
            pf_last_q   <= 1'b0;
            pf_r_q      <= '0;
            pf_i_q      <= '0;
            out_valid_q <= 1'b0;
            out_first_q <= 1'b0;
            out_last_q  <= 1'b0;
            out_r_q     <= '0;
            out_i_q     <= '0;
        end else begin
            full_q      <= full_d;
            wr_bank_q   <= wr_bank_d;
            wr_cnt_q    <= wr_cnt_d;
            overflow_q  <= overflow_d;
            rd_bank_q   <= rd_bank_d;
            rd_cnt_q    <= rd_cnt_d;
            state_q     <= state_d;
            pf_valid_q  <= pf_valid_d;
            pf_first_q  <= pf_first_d;
            pf_last_q   <= pf_last_d;
            pf_r_q      <= pf_r_d;
            pf_i_q      <= pf_i_d;
            out_valid_q <= out_valid_d;
            out_first_q <= out_first_d;
            out_last_q  <= out_last_d;
            out_r_q     <= out_r_d;
            out_i_q     <= out_i_d;
        end
    end

    assign Data_out_r = out_r_q;
    assign Data_out_i = out_i_q;
    assign out_valid  = out_valid_q;
    assign out_first  = out_first_q;
    assign out_last   = out_last_q;
    assign overflow   = overflow_q;

endmodule

// File: tb/tb_fft_bitrev_reorder.sv
// Randomized bench for fft_bitrev_reorder against a frame-level reorder/rescale model.
// Honours FFT_OUT_SAT_EN in the reference rounding to match the build under test.
module tb_fft_bitrev_reorder;

    logic        CLK = 1'b0;
    logic        RST;
    logic        in_valid;
    logic [31:0] in_r, in_i;
    logic [15:0] Data_out_r, Data_out_i;
    logic        out_valid, out_ready, out_first, out_last, overflow;

    int n_checks = 0;
    int n_errors = 0;
    int ready_mode = 0;

    typedef struct {
        logic [15:0] re;
        logic [15:0] im;
        bit          first;
        bit          last;
    } exp_t;
    exp_t exp_q[$];

    fft_bitrev_reorder dut (
        .CLK(CLK), .RST(RST), .in_valid(in_valid), .in_r(in_r), .in_i(in_i),
        .Data_out_r(Data_out_r), .Data_out_i(Data_out_i), .out_valid(out_valid),
        .out_ready(out_ready), .out_first(out_first), .out_last(out_last),
        .overflow(overflow)
    );

    always #5 CLK = ~CLK;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
        end
    endtask

    function automatic int ref_bitrev(input int n);
        int r = 0;
        int v = n;
        for (int b = 0; b < 8; b++) begin
            r = r * 2 + v % 2;
            v = v / 2;
        end
        return r;
    endfunction

    function automatic logic [15:0] ref_round(input logic [31:0] x);
        longint v, q;
        v = longint'(signed'(x)) + 128;
        q = v / 256;
        if (v % 256 != 0 && v < 0) q = q - 1;
`ifdef FFT_OUT_SAT_EN
        if (q > 32767) q = 32767;
        if (q < -32768) q = -32768;
`endif
        return 16'(q);
    endfunction

    function automatic logic [31:0] rnd_word();
        if ($urandom_range(0, 3) == 0) return $urandom;
        return 32'($urandom_range(0, 32'hFFFFFF)) - 32'h800000;
    endfunction

    // mode 0: index ramp, 1: random, 2: random with rounding corner cases
    task automatic feed_frame(input int mode, input bit accept);
        logic [31:0] fr_r[256];
        logic [31:0] fr_i[256];
        exp_t e;
        for (int k = 0; k < 256; k++) begin
            fr_r[k] = (mode == 0) ? 32'(k << 8) : rnd_word();
            fr_i[k] = (mode == 0) ? 32'h0 : rnd_word();
        end
        if (mode == 2) begin
            fr_r[0]   = 32'h0000_0180;
            fr_r[128] = 32'hFFFF_FE80;
            fr_r[64]  = 32'h0100_0000;
            fr_i[192] = 32'hFF00_0000;
            fr_r[32]  = 32'hFFFF_FF80;
            fr_r[160] = 32'hFFFF_FF7F;
            fr_i[96]  = 32'h0000_007F;
        end
        for (int k = 0; k < 256; k++) begin
            @(posedge CLK); #1;
            in_valid = 1'b1;
            in_r     = fr_r[k];
            in_i     = fr_i[k];
            if (k == 255 && accept) begin
                for (int n = 0; n < 256; n++) begin
                    e.re    = ref_round(fr_r[ref_bitrev(n)]);
                    e.im    = ref_round(fr_i[ref_bitrev(n)]);
                    e.first = (n == 0);
                    e.last  = (n == 255);
                    exp_q.push_back(e);
                end
            end
        end
    endtask

    task automatic go_idle();
        @(posedge CLK); #1;
        in_valid = 1'b0;
    endtask

    task automatic drain();
        int b = 0;
        while (exp_q.size() != 0 && b < 3000) begin
            @(negedge CLK);
            b++;
        end
        check("drain_empty", 64'(exp_q.size()), 0);
        repeat (10) @(negedge CLK);
    endtask

    // out_ready driver: 0 = low, 1 = high, 2 = pattern 1,0,0,1
    initial begin
        int ph = 0;
        out_ready = 1'b0;
        forever begin
            @(posedge CLK); #1;
            case (ready_mode)
                0: out_ready = 1'b0;
                1: out_ready = 1'b1;
                default: begin
                    out_ready = (ph == 0) || (ph == 3);
                    ph = (ph + 1) % 4;
                end
            endcase
        end
    end

    // Output monitor: scoreboard on handshakes, stability while stalled
    initial begin
        bit          stalled = 1'b0;
        logic [33:0] held = '0;
        exp_t        e;
        forever begin
            @(negedge CLK);
            if (stalled) begin
                check("stall_valid", 64'(out_valid), 1);
                check("stall_hold", 64'({Data_out_r, Data_out_i, out_first, out_last}), 64'(held));
            end
            if (out_valid && out_ready) begin
                if (exp_q.size() == 0) begin
                    check("unexpected_out", 1, 0);
                end else begin
                    e = exp_q.pop_front();
                    check("out_r", 64'(Data_out_r), 64'(e.re));
                    check("out_i", 64'(Data_out_i), 64'(e.im));
                    check("out_first", 64'(out_first), 64'(e.first));
                    check("out_last", 64'(out_last), 64'(e.last));
                end
            end
            stalled = out_valid && !out_ready;
            held    = {Data_out_r, Data_out_i, out_first, out_last};
        end
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int wait_n, gaps;
        RST = 1'b0; in_valid = 1'b0; in_r = '0; in_i = '0;
        repeat (3) @(posedge CLK);
        #1 RST = 1'b1;
        @(negedge CLK);
        check("rst_valid", 64'(out_valid), 0);
        check("rst_first", 64'(out_first), 0);
        check("rst_last", 64'(out_last), 0);
        check("rst_ovf", 64'(overflow), 0);
        check("rst_data_r", 64'(Data_out_r), 0);
        check("rst_data_i", 64'(Data_out_i), 0);

        // Index ramp and output latency
        ready_mode = 1;
        feed_frame(0, 1'b1);
        go_idle();
        @(negedge CLK); check("lat_e0", 64'(out_valid), 0);
        @(negedge CLK); check("lat_e1", 64'(out_valid), 0);
        @(negedge CLK); check("lat_e2", 64'(out_valid), 1);
        drain();

        // Rounding corner cases
        feed_frame(2, 1'b1);
        go_idle();
        drain();

        // Backpressure over two back-to-back frames
        ready_mode = 2;
        feed_frame(1, 1'b1);
        feed_frame(1, 1'b1);
        go_idle();
        drain();
        check("bp_ovf", 64'(overflow), 0);

        // Overflow: third frame dropped while output is blocked
        ready_mode = 0;
        feed_frame(1, 1'b1);
        feed_frame(1, 1'b1);
        feed_frame(1, 1'b0);
        go_idle();
        repeat (5) @(negedge CLK);
        check("ovf_set", 64'(overflow), 1);
        ready_mode = 1;
        drain();
        check("ovf_sticky", 64'(overflow), 1);

        // Reset after input 100 of a frame
        for (int k = 0; k <= 100; k++) begin
            @(posedge CLK); #1;
            in_valid = 1'b1;
            in_r = rnd_word();
            in_i = rnd_word();
        end
        @(posedge CLK); #1;
        RST = 1'b0; in_valid = 1'b0;
        @(posedge CLK); #1;
        RST = 1'b1;
        @(negedge CLK);
        check("mid_rst_valid", 64'(out_valid), 0);
        check("mid_rst_data_r", 64'(Data_out_r), 0);
        check("mid_rst_data_i", 64'(Data_out_i), 0);
        check("mid_rst_ovf", 64'(overflow), 0);
        repeat (20) @(negedge CLK);
        check("mid_rst_quiet", 64'(out_valid), 0);
        feed_frame(1, 1'b1);
        go_idle();
        drain();

        // Continuous streaming of 8 frames
        fork
            begin
                for (int f = 0; f < 8; f++) feed_frame(1, 1'b1);
                go_idle();
            end
            begin
                wait_n = 0;
                gaps = 0;
                @(negedge CLK);
                while (!out_valid && wait_n < 1000) begin
                    @(negedge CLK);
                    wait_n++;
                end
                check("stream_start", 64'(wait_n < 1000), 1);
                for (int i = 1; i < 2048; i++) begin
                    @(negedge CLK);
                    if (!out_valid) gaps++;
                end
                check("stream_gaps", 64'(gaps), 0);
            end
        join
        drain();
        check("stream_ovf", 64'(overflow), 0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
